acq_wnd_seq: RTL and testbench
==============================

# acq_wnd_seq

Echo acquisition-window sequencer: the initiator side of the `ACQ_WND`/`DONE` handshake consumed by the ADC acquisition window generator.
- On `START` it emits `NUM_ECHOES` acquisition windows, one per echo period, at a programmable offset and length.
- It checks that the downstream generator returns one `DONE` per window.
- It reports sequence completion and overrun.
- It sits between the pulse-sequence controller and the ADC acquisition path.

## Interface
- `ECHO_CNT_WIDTH`, 16, width of echo count and index.
- `PERIOD_WIDTH`, 32, width of echo period, window delay and window length.
- `CLK` input 1: system clock; all logic is on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `START` input 1: sampled only in IDLE; a one-cycle pulse begins a sequence.
- `ABORT` input 1: synchronous; terminates any active sequence.
- `NUM_ECHOES` input ECHO_CNT_WIDTH: number of windows; latched on `START`.
- `ECHO_PERIOD` input PERIOD_WIDTH: cycles per echo; latched on `START`; values below 2 are treated as 2.
- `WND_DELAY` input PERIOD_WIDTH: offset from period start to window rise; latched on `START`.
- `WND_LEN` input PERIOD_WIDTH: window length in cycles; latched on `START`.
- `ACQ_DONE` input 1: one-cycle `DONE` pulse returned by the acquisition window generator.
- `ACQ_WND` output 1: acquisition window, registered.
- `ECHO_IDX` output ECHO_CNT_WIDTH: index of the current echo, 0-based.
- `BUSY` output 1: high from the cycle after `START` until `SEQ_DONE` or abort.
- `SEQ_DONE` output 1: one-cycle pulse when the sequence completes normally.
- `OVERRUN` output 1: sticky error flag; cleared on an accepted `START`.

## Operation
- States are IDLE, RUN, DRAIN and FINISH.
- IDLE:
  - `START`=1 latches all parameters, clears `OVERRUN`, period counter `pcnt`=0, `ECHO_IDX`=0 and `pending`=0.
  - Next state is RUN, or FINISH if `NUM_ECHOES`=0.
- RUN:
  - `pcnt` increments every cycle.
  - When `pcnt`=P-1 (P = effective period), `pcnt` wraps to 0.
  - At the wrap, `ECHO_IDX` increments; on the last echo, the state moves to DRAIN instead.
- Window rule:
  - `ACQ_WND`=1 exactly in cycles where WND_DELAY ≤ `pcnt` < min(WND_DELAY+WND_LEN, P-1).
  - The sum is computed at PERIOD_WIDTH+1 bits, so it never wraps.
  - The last cycle of every period therefore always has `ACQ_WND`=0, which guarantees a falling edge between echoes.
  - If WND_LEN=0 or WND_DELAY ≥ P-1, the echo produces no window and expects no `DONE`.
- Handshake:
  - On each window rising edge, if `pending`=1 then set `OVERRUN`; then `pending`=1.
  - `ACQ_DONE`=1 clears `pending`.
  - `ACQ_DONE` while `pending`=0 is ignored.
  - A rising edge and `ACQ_DONE` in the same cycle: the `DONE` is credited to the previous window first, so no overrun.
- DRAIN:
  - If `pending`=0, go to FINISH immediately.
  - Otherwise wait for `ACQ_DONE` for at most P cycles.
  - On timeout, set `OVERRUN` and go to FINISH.
- FINISH: assert `SEQ_DONE` for one cycle, deassert `BUSY`, return to IDLE.
- ABORT:
  - In any non-IDLE state, the next cycle is IDLE.
  - `ACQ_WND`=0, `BUSY`=0, no `SEQ_DONE`.
  - `OVERRUN` and `ECHO_IDX` keep their values.
- `START` while not in IDLE is ignored.
- `ECHO_IDX` holds its last value in IDLE.

## Timing
- Reset values: `ACQ_WND`=0, `ECHO_IDX`=0, `BUSY`=0, `SEQ_DONE`=0, `OVERRUN`=0; state IDLE.
- Reset mid-sequence forces these values immediately; the window drops asynchronously.
- `START` sampled at edge k:
  - `BUSY`=1 and `pcnt`=0 from cycle k+1.
  - The first `ACQ_WND` rise is in cycle k+1+WND_DELAY.
- Echo n window starts in cycle k+1+n·P+WND_DELAY.
- The last period ends in cycle k+NUM_ECHOES·P.
- `SEQ_DONE`:
  - Asserted 2 cycles after the last period ends if `pending`=0 at that point.
  - Otherwise asserted 1 cycle after the final `ACQ_DONE`, or after the timeout.
- `NUM_ECHOES`=0: `SEQ_DONE` in cycle k+1; `BUSY` stays 0.
- `ABORT` at edge j: `ACQ_WND`=0 and `BUSY`=0 from cycle j+1.

## Test plan
- Nominal run:
  - Stimulus: `NUM_ECHOES`=3, `ECHO_PERIOD`=20, `WND_DELAY`=2, `WND_LEN`=5; responder model pulses `ACQ_DONE` 3 cycles after each window falls.
  - Required response: three 5-cycle windows starting at k+3, k+23, k+43; `ECHO_IDX` steps 0,1,2; one `SEQ_DONE`; `OVERRUN`=0.
- Zero echoes: `NUM_ECHOES`=0 -> `SEQ_DONE` at k+1, no `ACQ_WND` activity, `BUSY` stays 0.
- Overrun:
  - Stimulus: same parameters as the nominal run, responder silent.
  - Required response: `OVERRUN` set at the second window rise; DRAIN times out after 20 cycles; `SEQ_DONE` still pulses; `OVERRUN` clears on the next `START`.
- Clipping: `ECHO_PERIOD`=10, `WND_DELAY`=4, `WND_LEN`=20 -> window high for `pcnt` 4..8, low at `pcnt` 9 every period.
- Abort and START-while-busy:
  - Stimulus: `ABORT` mid-window in echo 1; `START` issued while RUN.
  - Required response: after `ABORT`, `ACQ_WND` low next cycle, no `SEQ_DONE`; the `START` in RUN is ignored, with no restart or parameter change.
- Reset mid-run: assert `RESET` low during a window -> all outputs go to reset values immediately; a fresh `START` after release runs the nominal sequence correctly.

Source files
------------

// File: rtl/acq_wnd_seq.sv
// Echo acquisition-window sequencer.
// Issues NUM_ECHOES acquisition windows, one per echo period, and tracks the
// ACQ_WND/DONE handshake with the downstream window generator. Reports normal
// completion on seq_done_o and a sticky overrun when a DONE is missing.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start_i; parameters latched on an accepted start
//   S_RUN    | stepping through echo periods, generating windows
//   S_DRAIN  | last period over; waiting up to one period for the last DONE
//   S_FINISH | one-cycle completion pulse, then back to idle
module acq_wnd_seq #(
    parameter int ECHO_CNT_WIDTH = 16,
    parameter int PERIOD_WIDTH   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [ECHO_CNT_WIDTH-1:0] num_echoes_i,
    input  logic [PERIOD_WIDTH-1:0]   echo_period_i,
    input  logic [PERIOD_WIDTH-1:0]   wnd_delay_i,
    input  logic [PERIOD_WIDTH-1:0]   wnd_len_i,
    input  logic                      acq_done_i,
    output logic                      acq_wnd_o,
    output logic [ECHO_CNT_WIDTH-1:0] echo_idx_o,
    output logic                      busy_o,
    output logic                      seq_done_o,
    output logic                      overrun_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [PERIOD_WIDTH-1:0]   pcnt_q, pcnt_d;
    logic [ECHO_CNT_WIDTH-1:0] echo_idx_q, echo_idx_d;
    logic [ECHO_CNT_WIDTH-1:0] num_q;
    logic [PERIOD_WIDTH-1:0]   per_q, dly_q, len_q;
    logic                      pend_q, pend_d;
    logic                      ovr_q, ovr_d;
    logic                      wnd_q, wnd_d;
    logic                      wnd_prev_q;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      load;
    logic [PERIOD_WIDTH-1:0]   per_in;
    logic [PERIOD_WIDTH-1:0]   per_e, dly_e, len_e;
    logic [PERIOD_WIDTH-1:0]   per_m1;
    logic [PERIOD_WIDTH:0]     wnd_sum, wnd_lim, wnd_end;
    logic                      wnd_rise;
    logic                      pend_after;
    logic                      last_cyc;
    logic                      last_echo;

    // Parameter selection and window bounds; the bounds use the incoming
    // values on the start cycle so a zero delay still opens in the first cycle.
    always_comb begin
        load       = (state_q == S_IDLE) && start_i;
        per_in     = (echo_period_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : echo_period_i;
        per_e      = load ? per_in      : per_q;
        dly_e      = load ? wnd_delay_i : dly_q;
        len_e      = load ? wnd_len_i   : len_q;
        per_m1     = per_q - PERIOD_WIDTH'(1);
        wnd_sum    = {1'b0, dly_e} + {1'b0, len_e};
        wnd_lim    = {1'b0, per_e - PERIOD_WIDTH'(1)};
        wnd_end    = (wnd_sum < wnd_lim) ? wnd_sum : wnd_lim;
        wnd_rise   = wnd_q && !wnd_prev_q;
        pend_after = pend_q && !acq_done_i;
        last_cyc   = (pcnt_q == per_m1);
        last_echo  = (echo_idx_q == (num_q - ECHO_CNT_WIDTH'(1)));
    end

    // Sequencer next-state, counters and handshake bookkeeping.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        echo_idx_d = echo_idx_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;

        // A DONE in the same cycle as a rise is credited to the older window.
        if (state_q != S_IDLE) begin
            pend_d = pend_after;
            if (wnd_rise) begin
                pend_d = 1'b1;
                if (pend_after) ovr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ovr_d      = 1'b0;
                    pend_d     = 1'b0;
                    pcnt_d     = '0;
                    echo_idx_d = '0;
                    state_d    = (num_echoes_i == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (last_cyc) begin
                    pcnt_d = '0;
                    if (last_echo) state_d = S_DRAIN;
                    else           echo_idx_d = echo_idx_q + ECHO_CNT_WIDTH'(1);
                end else begin
                    pcnt_d = pcnt_q + PERIOD_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (!pend_after) begin
                    state_d = S_FINISH;
                end else if (last_cyc) begin
                    ovr_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    pcnt_d = pcnt_q + PERIOD_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            ovr_d      = ovr_q;
            echo_idx_d = echo_idx_q;
        end
    end

    // Registered outputs derived from the next state so they line up with pcnt.
    always_comb begin
        wnd_d  = (state_d == S_RUN) && (pcnt_d >= dly_e) && ({1'b0, pcnt_d} < wnd_end);
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_FINISH);
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            echo_idx_q <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            wnd_q      <= 1'b0;
            wnd_prev_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            echo_idx_q <= echo_idx_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            wnd_q      <= wnd_d;
            wnd_prev_q <= wnd_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Sequence parameters, captured only on an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_q <= '0;
            per_q <= PERIOD_WIDTH'(2);
            dly_q <= '0;
            len_q <= '0;
        end else if (load) begin
            num_q <= num_echoes_i;
            per_q <= per_in;
            dly_q <= wnd_delay_i;
            len_q <= wnd_len_i;
        end
    end

    assign acq_wnd_o  = wnd_q;
    assign echo_idx_o = echo_idx_q;
    assign busy_o     = busy_q;
    assign seq_done_o = done_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_acq_wnd_seq.sv
// Bench for acq_wnd_seq: a window/done event scoreboard filled from a small
// timing model whenever a sequence is started, drained by a negedge monitor.
module tb_acq_wnd_seq;

    localparam int EW = 16;
    localparam int PW = 32;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int lbl;
        int idx;
        int ovr;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [EW-1:0] num_echoes = '0;
    logic [PW-1:0] echo_period = '0;
    logic [PW-1:0] wnd_delay = '0;
    logic [PW-1:0] wnd_len = '0;
    logic          acq_done = 1'b0;
    logic          acq_wnd;
    logic [EW-1:0] echo_idx;
    logic          busy;
    logic          seq_done;
    logic          overrun;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  sb[$];
    int   resp_q[$];
    bit   resp_en = 1'b0;
    bit   prev_w = 1'b0;
    int   ks;

    acq_wnd_seq #(.ECHO_CNT_WIDTH(EW), .PERIOD_WIDTH(PW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .num_echoes_i (num_echoes),
        .echo_period_i(echo_period),
        .wnd_delay_i  (wnd_delay),
        .wnd_len_i    (wnd_len),
        .acq_done_i   (acq_done),
        .acq_wnd_o    (acq_wnd),
        .echo_idx_o   (echo_idx),
        .busy_o       (busy),
        .seq_done_o   (seq_done),
        .overrun_o    (overrun)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic push_ev(input int kind, input int lbl, input int idx, input int ovr);
        ev_t e;
        e.kind = kind;
        e.lbl  = lbl;
        e.idx  = idx;
        e.ovr  = ovr;
        sb.push_back(e);
    endtask

    // Expected events for a sequence whose start is sampled at the edge that
    // opens cycle label k0 (labels count rising edges seen so far).
    task automatic push_model(input int k0, input int n, input int p, input int d,
                              input int l, input bit silent);
        int pe, hi, dlast, done_lbl, done_ovr;
        bit has;
        pe  = (p < 2) ? 2 : p;
        hi  = (d + l < pe - 1) ? d + l : pe - 1;
        has = (l > 0) && (d < hi);
        if (has) begin
            for (int e = 0; e < n; e++) begin
                push_ev(EV_RISE, k0 + e * pe + d, e, (silent && e >= 2) ? 1 : 0);
                push_ev(EV_FALL, k0 + e * pe + hi, 0, (silent && e >= 1) ? 1 : 0);
            end
        end
        done_ovr = 0;
        if (n == 0) begin
            done_lbl = k0;
        end else if (!has) begin
            done_lbl = k0 + n * pe + 1;
        end else if (silent) begin
            done_lbl = k0 + n * pe + pe;
            done_ovr = 1;
        end else begin
            dlast    = k0 + (n - 1) * pe + hi + 3;
            done_lbl = (dlast <= k0 + n * pe - 1) ? k0 + n * pe + 1 : dlast + 1;
        end
        push_ev(EV_DONE, done_lbl, 0, done_ovr);
    endtask

    task automatic drive_params(input int n, input int p, input int d, input int l);
        num_echoes  = EW'(n);
        echo_period = PW'(p);
        wnd_delay   = PW'(d);
        wnd_len     = PW'(l);
    endtask

    task automatic start_seq(input int n, input int p, input int d, input int l, input bit silent);
        @(negedge clk);
        drive_params(n, p, d, l);
        start   = 1'b1;
        ks      = cyc + 1;
        resp_en = !silent;
        push_model(ks, n, p, d, l, silent);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_lbl(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = 0;
        while (sb.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) chk("sb_timeout", sb.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic ev_seen(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("spurious_evt", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("evt_kind", kind, e.kind);
            chk("evt_cycle", cyc, e.lbl);
            chk("evt_overrun", overrun, e.ovr);
            if (kind == EV_RISE) begin
                chk("rise_echo_idx", echo_idx, e.idx);
                chk("rise_busy", busy, 1);
            end
            if (kind == EV_DONE) chk("done_busy", busy, 0);
        end
    endtask

    // Monitor and DONE responder; acts at the falling edge, clear of the DUT edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_w   = 1'b0;
            acq_done = 1'b0;
        end else begin
            acq_done = 1'b0;
            if (resp_q.size() != 0 && resp_q[0] == cyc) begin
                void'(resp_q.pop_front());
                acq_done = resp_en;
            end
            if (acq_wnd && !prev_w) ev_seen(EV_RISE);
            if (!acq_wnd && prev_w) begin
                ev_seen(EV_FALL);
                resp_q.push_back(cyc + 3);
            end
            if (seq_done) ev_seen(EV_DONE);
            prev_w = acq_wnd;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_acq_wnd", acq_wnd, 0);
        chk("rst_echo_idx", echo_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // nominal run with responder
        start_seq(3, 20, 2, 5, 0);
        wait_drain(200);

        // zero echoes
        start_seq(0, 20, 2, 5, 0);
        chk("zero_busy", busy, 0);
        wait_drain(20);

        // silent responder: overrun and drain timeout
        start_seq(3, 20, 2, 5, 1);
        wait_drain(200);
        chk("ovr_sticky", overrun, 1);

        // clipping; last DONE lands in drain; overrun cleared by the start
        start_seq(3, 10, 4, 20, 0);
        chk("ovr_cleared", overrun, 0);
        wait_drain(200);

        // period below 2, zero length, delay at the period end
        start_seq(2, 1, 0, 5, 1);
        wait_drain(50);
        start_seq(2, 8, 1, 0, 0);
        wait_drain(50);
        start_seq(1, 8, 7, 3, 0);
        wait_drain(50);

        // abort mid-window of echo 1, with an ignored start while running
        @(negedge clk);
        drive_params(3, 20, 2, 5);
        start   = 1'b1;
        ks      = cyc + 1;
        resp_en = 1'b1;
        push_ev(EV_RISE, ks + 2, 0, 0);
        push_ev(EV_FALL, ks + 7, 0, 0);
        push_ev(EV_RISE, ks + 22, 1, 0);
        push_ev(EV_FALL, ks + 25, 0, 0);
        @(negedge clk);
        start = 1'b0;
        wait_lbl(ks + 5);
        drive_params(7, 9, 0, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_lbl(ks + 24);
        chk("abort_pre_wnd", acq_wnd, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wnd", acq_wnd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx_kept", echo_idx, 1);
        repeat (60) @(negedge clk);
        chk("abort_sb_empty", sb.size(), 0);

        // reset during a window, then a fresh nominal run
        start_seq(3, 20, 2, 5, 0);
        wait_lbl(ks + 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acq_wnd", acq_wnd, 0);
        chk("arst_echo_idx", echo_idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_seq_done", seq_done, 0);
        chk("arst_overrun", overrun, 0);
        sb.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_seq(3, 20, 2, 5, 0);
        wait_drain(200);

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
